// File: rtl/cga_intr_pkg.sv
// Shared definitions for the CGA interrupt controller: command codes,
// gate FSM encoding and default geometry.
package cga_intr_pkg;

  localparam int unsigned CMD_W = 3;

  localparam logic [CMD_W-1:0] CMD_NOP    = 3'b000;
  localparam logic [CMD_W-1:0] CMD_LDPIE  = 3'b001;
  localparam logic [CMD_W-1:0] CMD_LDPID  = 3'b010;
  localparam logic [CMD_W-1:0] CMD_SETPID = 3'b011;
  localparam logic [CMD_W-1:0] CMD_CLRPID = 3'b100;
  localparam logic [CMD_W-1:0] CMD_ION    = 3'b101;
  localparam logic [CMD_W-1:0] CMD_IOF    = 3'b110;
  localparam logic [CMD_W-1:0] CMD_EXIT   = 3'b111;

  localparam int unsigned DEF_NUM_LEVELS = 16;
  localparam int unsigned DEF_LVL_W      = 4;
  localparam int unsigned DEF_DATA_W     = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } gate_state_e;

  // One software command as presented on the command strobe
  typedef struct packed {
    logic [CMD_W-1:0] op;
    logic             valid;
  } gate_cmd_t;

endpackage : cga_intr_pkg

// File: rtl/cga_intr_level_gate_if.sv
// Command/data, hardware request and sequencer handshake bundle of the
// interrupt level gate. master = driver side (CPU/sequencer), slave = gate.
interface cga_intr_level_gate_if #(
  parameter int unsigned NUM_LEVELS = 16,
  parameter int unsigned LVL_W      = 4,
  parameter int unsigned DATA_W     = 16
);
  import cga_intr_pkg::*;

  logic [CMD_W-1:0]      CMD;
  logic                  CMD_VALID;
  logic [DATA_W-1:0]     FIDB;
  logic [NUM_LEVELS-1:0] IRQ_IN;
  logic                  INT_ACK;

  logic [NUM_LEVELS-1:0] PIE;
  logic [NUM_LEVELS-1:0] PID;
  logic                  GEN;
  logic [LVL_W-1:0]      CUR_LVL;
  logic                  INT_REQ;
  logic [LVL_W-1:0]      INT_LVL;

  modport master (
    output CMD, CMD_VALID, FIDB, IRQ_IN, INT_ACK,
    input  PIE, PID, GEN, CUR_LVL, INT_REQ, INT_LVL
  );

  modport slave (
    input  CMD, CMD_VALID, FIDB, IRQ_IN, INT_ACK,
    output PIE, PID, GEN, CUR_LVL, INT_REQ, INT_LVL
  );

endinterface : cga_intr_level_gate_if

// File: rtl/cga_intr_prio_enc.sv
// Highest-set-bit encoder: index of the most significant request plus an
// any-request flag. Purely combinational.
module cga_intr_prio_enc #(
  parameter int unsigned NUM_LEVELS = 16,
  parameter int unsigned LVL_W      = 4
) (
  input  logic [NUM_LEVELS-1:0] req_i,
  output logic [LVL_W-1:0]      top_lvl_o_c,
  output logic                  any_o_c
);

  // Ascending scan so the last hit is the highest level
  always_comb begin
    top_lvl_o_c = '0;
    any_o_c     = 1'b0;
    for (int i = 0; i < int'(NUM_LEVELS); i++) begin
      if (req_i[i]) begin
        top_lvl_o_c = LVL_W'(i);
        any_o_c     = 1'b1;
      end
    end
  end

endmodule : cga_intr_prio_enc

// File: rtl/cga_intr_level_gate.sv
// Interrupt level gate: PIE/PID/GEN/CUR_LVL registers, command decode and
// the REQ/ACK handshake that hands the best eligible level to the sequencer.
module cga_intr_level_gate
  import cga_intr_pkg::*;
#(
  parameter int unsigned NUM_LEVELS = DEF_NUM_LEVELS,
  parameter int unsigned LVL_W      = DEF_LVL_W,
  parameter int unsigned DATA_W     = DEF_DATA_W
) (
  input  logic MCLK,
  input  logic RESET,
  cga_intr_level_gate_if.slave bus
);

  logic [NUM_LEVELS-1:0] pie_q, pie_d;
  logic [NUM_LEVELS-1:0] pid_q, pid_d;
  logic                  gen_q, gen_d;
  logic [LVL_W-1:0]      cur_lvl_q, cur_lvl_d;
  logic                  int_req_q, int_req_d;
  logic [LVL_W-1:0]      int_lvl_q, int_lvl_d;
  gate_state_e           state_q, state_d;

  logic [DATA_W-1:0]     fidb;
  logic [LVL_W-1:0]      fidb_lvl;
  logic                  fidb_lvl_ok;
  gate_cmd_t             cmd;
  logic [NUM_LEVELS-1:0] eligible;
  logic [LVL_W-1:0]      top_lvl;
  logic                  top_any;
  logic                  want_req;

  assign fidb        = bus.FIDB;
  assign fidb_lvl    = fidb[LVL_W-1:0];
  assign fidb_lvl_ok = 32'(fidb_lvl) < NUM_LEVELS;
  assign cmd         = '{op: bus.CMD, valid: bus.CMD_VALID};

  // Level 0 is background and never competes
  assign eligible = pid_q & pie_q & ~NUM_LEVELS'(1);

  cga_intr_prio_enc #(
    .NUM_LEVELS (NUM_LEVELS),
    .LVL_W      (LVL_W)
  ) u_prio_enc (
    .req_i       (eligible),
    .top_lvl_o_c (top_lvl),
    .any_o_c     (top_any)
  );

  assign want_req = gen_q && top_any && (top_lvl > cur_lvl_q);

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      pie_q     <= '0;
      pid_q     <= '0;
      gen_q     <= 1'b0;
      cur_lvl_q <= '0;
      int_req_q <= 1'b0;
      int_lvl_q <= '0;
      state_q   <= ST_IDLE;
    end else begin
      pie_q     <= pie_d;
      pid_q     <= pid_d;
      gen_q     <= gen_d;
      cur_lvl_q <= cur_lvl_d;
      int_req_q <= int_req_d;
      int_lvl_q <= int_lvl_d;
      state_q   <= state_d;
    end
  end

  always_comb begin
    pie_d     = pie_q;
    pid_d     = pid_q;
    gen_d     = gen_q;
    cur_lvl_d = cur_lvl_q;
    int_req_d = int_req_q;
    int_lvl_d = int_lvl_q;
    state_d   = state_q;

    if (cmd.valid) begin
      case (cmd.op)
        CMD_LDPIE:  pie_d = fidb[NUM_LEVELS-1:0];
        CMD_LDPID:  pid_d = fidb[NUM_LEVELS-1:0];
        CMD_SETPID: if (fidb_lvl_ok) pid_d[fidb_lvl] = 1'b1;
        CMD_CLRPID: if (fidb_lvl_ok) pid_d[fidb_lvl] = 1'b0;
        CMD_ION:    gen_d = 1'b1;
        CMD_IOF:    gen_d = 1'b0;
        CMD_EXIT: begin
          pid_d[cur_lvl_q] = 1'b0;
          cur_lvl_d        = '0;
        end
        default: ;
      endcase
    end

    // Hardware requests override any software clear in the same cycle
    pid_d = pid_d | bus.IRQ_IN;

    case (state_q)
      ST_IDLE: begin
        if (want_req) begin
          state_d   = ST_REQ;
          int_req_d = 1'b1;
          int_lvl_d = top_lvl;
        end
      end
      ST_REQ: begin
        if (bus.INT_ACK) begin
          cur_lvl_d = int_lvl_q;
          int_req_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (!(pid_d[int_lvl_q] && pie_d[int_lvl_q]) || !gen_d) begin
          int_req_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.PIE     = pie_q;
  assign bus.PID     = pid_q;
  assign bus.GEN     = gen_q;
  assign bus.CUR_LVL = cur_lvl_q;
  assign bus.INT_REQ = int_req_q;
  assign bus.INT_LVL = int_lvl_q;

endmodule : cga_intr_level_gate
